// File: rtl/fractal_stream_packer_if.sv
// AXI4-Stream video link (24-bit RGB, tuser = start of frame, tlast = end of line).
interface fractal_stream_packer_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/fractal_stream_packer.sv
// Packs colorizer pixel beats into an AXI4-Stream video master through a FIFO,
// pausing the fractal generator early and resyncing to the next frame after a loss.
module fractal_stream_packer #(
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [23:0]                    data_in,
    input  logic                           frame_start_in,
    input  logic                           line_end_in,
    input  logic                           data_enable_in,
    output logic                           stall,
    output logic                           overflow,
    fractal_stream_packer_if.master        m_axis
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - STALL_MARGIN);

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;

    logic [25:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic          overflow_q, overflow_d;
    logic          stall_q, stall_d;

    logic          wr_req, push, pop, drop, head_vld;
    logic [25:0]   head;

    always_comb begin
        head_vld = (count_q != '0);
        pop      = head_vld & m_axis.tready;
        // Outside a frame only a start-of-frame beat is worth keeping.
        wr_req   = data_enable_in & ((state_q == RUN) | frame_start_in);
        push     = wr_req & ((count_q != FULL_LVL) | pop);
        drop     = wr_req & ~push;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A lost beat corrupts the frame, so drop the remainder until the next SOF.
        state_d = state_q;
        if (drop) begin
            state_d = WAIT_SOF;
        end else if (push && frame_start_in) begin
            state_d = RUN;
        end

        overflow_d = overflow_q | drop;
        stall_d    = (count_d >= STALL_LVL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= WAIT_SOF;
            overflow_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            stall_q    <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {frame_start_in, line_end_in, data_in};
        end
    end

    // Payload is masked while empty so the bus reads all-zero out of reset.
    assign head          = mem_q[rd_ptr_q];
    assign m_axis.tvalid = head_vld;
    assign m_axis.tdata  = head_vld ? head[23:0] : '0;
    assign m_axis.tlast  = head_vld & head[24];
    assign m_axis.tuser  = head_vld & head[25];
    assign stall         = stall_q;
    assign overflow      = overflow_q;
endmodule

// File: doc/fractal_stream_packer.md
Name: fractal_stream_packer

Overview:
- Sink end of the pixel sideband interface driven by fractal_colorizer: `data_in`[23:0] RGB qualified by `frame_start_in`, `line_end_in` and `data_enable_in`.
- Repacks the beats into an AXI4-Stream video master: `tuser` = start of frame, `tlast` = end of line.
- A FIFO absorbs downstream backpressure. The colorizer cannot be stalled, so the block raises `stall` early to pause the upstream fractal generator, and flags any loss on `overflow`.
- Sits between the colorizer and the VDMA/display stream input.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- STALL_MARGIN, 4, free entries remaining at which `stall` asserts; must be less than DEPTH.

Ports:
- clk  in  1  Clock; all logic on rising edge.
- reset  in  1  Asynchronous, active-high reset.
- data_in  in  24  RGB pixel from colorizer.
- frame_start_in  in  1  First pixel of frame; valid only with data_enable_in.
- line_end_in  in  1  Last pixel of line; valid only with data_enable_in.
- data_enable_in  in  1  Beat valid.
- stall  out  1  Upstream pause request; registered.
- overflow  out  1  Sticky: a beat was lost since reset.
- m_axis_tdata  out  24  Pixel.
- m_axis_tvalid  out  1  Output beat valid.
- m_axis_tready  in  1  Downstream ready.
- m_axis_tuser  out  1  Start of frame.
- m_axis_tlast  out  1  End of line.

Behaviour:
- Reset, asynchronous and immediate:
  - FIFO empty; all outputs 0.
  - state = WAIT_SOF; overflow cleared.
- Input beat: cycle with data_enable_in=1. frame_start_in and line_end_in are ignored when data_enable_in=0.
- State machine:
  - WAIT_SOF: beats without frame_start_in are discarded and are not overflow. A beat with frame_start_in=1 is written and the state moves to RUN.
  - RUN: every beat is written. Another frame_start_in beat is written normally with tuser=1; no state change.
- FIFO entry: {tuser=frame_start_in, tlast=line_end_in, data_in}, 26 bits.
- Write acceptance: accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Write at full with no pop:
  - the beat is dropped;
  - overflow is set to 1 next cycle and stays 1 until reset;
  - state moves to WAIT_SOF, which discards the rest of the corrupted frame.
- Pop: m_axis_tvalid & m_axis_tready.
- Occupancy: count is in 0..DEPTH and changes by +1, -1 or 0 per cycle (push and pop together leave it unchanged).
- Latency and output timing:
  - A beat written at edge n with an empty FIFO appears on m_axis_* (tvalid=1) after edge n; minimum latency 1 cycle.
  - No combinational path from any input to m_axis_*.
- AXI-Stream rules:
  - While tvalid=1 and tready=0, tdata, tuser and tlast hold stable.
  - tvalid never deasserts without a pop.
  - Order is strictly FIFO.
- stall: registered; equals 1 in the cycle after count >= DEPTH-STALL_MARGIN is evaluated at a clock edge, otherwise 0.
- Upstream contract: the upstream must stop within STALL_MARGIN-1 beats. Beats arriving after that are still accepted if space remains.
- Simultaneous frame_start_in and line_end_in on one beat (1-pixel line): both sideband bits are stored.
- Reset mid-frame or mid-handshake: FIFO contents are lost; tvalid drops to 0 immediately, with no AXI protocol obligation through reset.

Test Plan:
- Pass-through: tready=1; after reset, 1 idle beat then frame_start beat 0x112233, then 0x445566 with line_end -> output tuser=1/0x112233 then tlast=1/0x445566, each one cycle after its input; stall=0, overflow=0.
- Pre-SOF discard: 5 beats without frame_start, then an SOF beat 0xABCDEF -> only 0xABCDEF emerges, with tuser=1; overflow=0.
- Backpressure and stall: DEPTH=16, tready=0, 12 consecutive beats -> stall=1 the cycle after the 12th write; release tready -> all 12 beats emerge in order; stall drops once count<12.
- Overflow resync: tready=0, 17 beats in frame A -> 17th dropped, overflow=1; then tready=1 -> 16 beats out. Further frame-A beats are discarded; next SOF frame B is passed intact; overflow stays 1.
- Full with simultaneous pop: FIFO at 16, tready=1 and a write in the same cycle -> write accepted, count stays 16, overflow=0.
- Async reset mid-stream: assert reset between edges with tvalid=1 -> tvalid, stall, overflow go to 0 without waiting for a clock edge; post-reset beats before the next SOF are discarded.
